// File: rtl/syn_fifo_ctrl.sv
// syn_fifo_ctrl: single-clock FIFO with standard or first-word-fall-through reads,
// occupancy count, almost-full/almost-empty flags, sticky error flags and flush.
//   clk, rst_n           clock, asynchronous active-low reset
//   flush                synchronous clear of pointers, count and error flags
//   wdata, winc, wfull   write data, write request, full flag
//   walmost_full         count >= AFULL_TH
//   rinc, rdata, rvalid  read request, read data, read data valid
//   rempty               no word available to read
//   ralmost_empty        count <= AEMPTY_TH
//   count                words held, including the FWFT output word
//   overflow, underflow  sticky error flags
module syn_fifo_ctrl #(
    parameter int DSIZE     = 32,
    parameter int ASIZE     = 9,
    parameter int FWFT      = 0,
    parameter int AFULL_TH  = (1 << ASIZE) - 4,
    parameter int AEMPTY_TH = 4,
    parameter     RAM_TYPE  = "block"
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic [DSIZE-1:0] wdata,
    input  logic             winc,
    output logic             wfull,
    output logic             walmost_full,
    input  logic             rinc,
    output logic [DSIZE-1:0] rdata,
    output logic             rvalid,
    output logic             rempty,
    output logic             ralmost_empty,
    output logic [ASIZE:0]   count,
    output logic             overflow,
    output logic             underflow
);
    localparam int DEPTH = 1 << ASIZE;
    localparam logic [ASIZE:0] FULL_CNT = (ASIZE + 1)'(DEPTH);
    localparam logic [ASIZE:0] AF_CNT   = (ASIZE + 1)'(AFULL_TH);
    localparam logic [ASIZE:0] AE_CNT   = (ASIZE + 1)'(AEMPTY_TH);

    (* ram_style = RAM_TYPE *) logic [DSIZE-1:0] mem [DEPTH];
    logic [ASIZE:0] wptr, rptr, count_nxt;
    logic           wr_acc, rd_acc, mem_rd, rempty_nxt;

    // In FWFT mode rdata is a prefetch register refilled from memory whenever it
    // is empty or being consumed; memory occupancy comes from the pointer compare.
    always_comb begin
        wr_acc     = winc && !wfull;
        rd_acc     = rinc && !rempty;
        count_nxt  = count + (ASIZE + 1)'(wr_acc) - (ASIZE + 1)'(rd_acc);
        mem_rd     = (FWFT != 0) ? (wptr != rptr) && (rempty || rd_acc) : rd_acc;
        rempty_nxt = (FWFT != 0) ? !mem_rd && (rempty || rd_acc) : count_nxt == '0;
    end

    always_ff @(posedge clk) begin
        if (rst_n && !flush && wr_acc)
            mem[wptr[ASIZE-1:0]] <= wdata;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr          <= '0;
            rptr          <= '0;
            count         <= '0;
            rdata         <= '0;
            rvalid        <= 1'b0;
            rempty        <= 1'b1;
            wfull         <= 1'b0;
            walmost_full  <= 1'b0;
            ralmost_empty <= 1'b1;
            overflow      <= 1'b0;
            underflow     <= 1'b0;
        end else if (flush) begin
            wptr          <= '0;
            rptr          <= '0;
            count         <= '0;
            rvalid        <= 1'b0;
            rempty        <= 1'b1;
            wfull         <= 1'b0;
            walmost_full  <= AF_CNT == '0;
            ralmost_empty <= 1'b1;
            overflow      <= 1'b0;
            underflow     <= 1'b0;
        end else begin
            wptr          <= wptr + (ASIZE + 1)'(wr_acc);
            rptr          <= rptr + (ASIZE + 1)'(mem_rd);
            count         <= count_nxt;
            rvalid        <= (FWFT != 0) ? !rempty_nxt : rd_acc;
            rempty        <= rempty_nxt;
            wfull         <= count_nxt == FULL_CNT;
            walmost_full  <= count_nxt >= AF_CNT;
            ralmost_empty <= count_nxt <= AE_CNT;
            overflow      <= overflow || (winc && wfull);
            underflow     <= underflow || (rinc && rempty);
            if (mem_rd)
                rdata <= mem[rptr[ASIZE-1:0]];
        end
    end
endmodule

// File: tb/tb_syn_fifo_ctrl.sv
// tb_syn_fifo_ctrl: scoreboard bench for standard (ASIZE 2 and 4) and FWFT (ASIZE 2) FIFOs.
module tb_syn_fifo_ctrl;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic flush [3];
    logic winc [3];
    logic rinc [3];
    logic [7:0] wdata [3];
    logic [7:0] rdata [3];
    logic wfull [3];
    logic walmost_full [3];
    logic rvalid [3];
    logic rempty [3];
    logic ralmost_empty [3];
    logic overflow [3];
    logic underflow [3];
    logic [4:0] count [3];
    int checks = 0;
    int errors = 0;
    int rcv [3];
    int sent [3];
    int base [3];
    logic acc [3];

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    for (genvar g = 0; g < 3; g++) begin : u
        localparam int AS = (g == 2) ? 4 : 2;
        localparam int D  = 1 << AS;
        localparam int AF = (g == 2) ? 12 : 3;
        localparam int AE = (g == 2) ? 4 : 1;
        localparam int FW = (g == 1) ? 1 : 0;
        logic [AS:0] cnt;
        logic [7:0] q [$];
        logic [7:0] ed;
        logic erv, ov, un;
        int mc;

        syn_fifo_ctrl #(.DSIZE(8), .ASIZE(AS), .FWFT(FW), .AFULL_TH(AF), .AEMPTY_TH(AE),
                        .RAM_TYPE("distributed")) dut (
            .clk(clk), .rst_n(rst_n), .flush(flush[g]), .wdata(wdata[g]), .winc(winc[g]),
            .wfull(wfull[g]), .walmost_full(walmost_full[g]), .rinc(rinc[g]), .rdata(rdata[g]),
            .rvalid(rvalid[g]), .rempty(rempty[g]), .ralmost_empty(ralmost_empty[g]),
            .count(cnt), .overflow(overflow[g]), .underflow(underflow[g]));
        assign count[g] = 5'(cnt);

        if (FW != 0) begin : m
            always @(negedge clk) begin
                logic racc, wacc;
                if (!rst_n) begin
                    q.delete(); mc = 0; ov = 0; un = 0;
                end else begin
                    check($sformatf("count%0d", g), cnt, mc);
                    check($sformatf("wfull%0d", g), wfull[g], mc == D);
                    check($sformatf("afull%0d", g), walmost_full[g], mc >= AF);
                    check($sformatf("aempty%0d", g), ralmost_empty[g], mc <= AE);
                    check($sformatf("ovf%0d", g), overflow[g], ov);
                    check($sformatf("unf%0d", g), underflow[g], un);
                    check($sformatf("rvalid%0d", g), rvalid[g], !rempty[g]);
                    racc = rinc[g] && !rempty[g];
                    if (racc) begin
                        if (q.size() == 0) check($sformatf("sb_empty%0d", g), q.size(), 1);
                        else begin
                            check($sformatf("data%0d", g), rdata[g], q.pop_front());
                            rcv[g]++;
                        end
                    end
                    un |= rinc[g] && rempty[g];
                    wacc = winc[g] && mc < D;
                    ov |= winc[g] && mc == D;
                    if (wacc) q.push_back(wdata[g]);
                    mc += int'(wacc) - int'(racc);
                    if (flush[g]) begin
                        q.delete(); mc = 0; ov = 0; un = 0;
                    end
                end
            end
        end else begin : m
            always @(negedge clk) begin
                logic racc, wacc;
                if (!rst_n) begin
                    q.delete(); mc = 0; ov = 0; un = 0; erv = 0;
                end else begin
                    check($sformatf("count%0d", g), cnt, mc);
                    check($sformatf("wfull%0d", g), wfull[g], mc == D);
                    check($sformatf("afull%0d", g), walmost_full[g], mc >= AF);
                    check($sformatf("aempty%0d", g), ralmost_empty[g], mc <= AE);
                    check($sformatf("ovf%0d", g), overflow[g], ov);
                    check($sformatf("unf%0d", g), underflow[g], un);
                    check($sformatf("rempty%0d", g), rempty[g], mc == 0);
                    check($sformatf("rvalid%0d", g), rvalid[g], erv);
                    if (erv) check($sformatf("data%0d", g), rdata[g], ed);
                    racc = rinc[g] && mc > 0;
                    un |= rinc[g] && mc == 0;
                    if (racc) begin
                        if (q.size() == 0) check($sformatf("sb_empty%0d", g), q.size(), 1);
                        else begin
                            ed = q.pop_front();
                            rcv[g]++;
                        end
                    end
                    erv = racc;
                    wacc = winc[g] && mc < D;
                    ov |= winc[g] && mc == D;
                    if (wacc) q.push_back(wdata[g]);
                    mc += int'(wacc) - int'(racc);
                    if (flush[g]) begin
                        q.delete(); mc = 0; ov = 0; un = 0; erv = 0;
                    end
                end
            end
        end
    end

    initial begin
        for (int i = 0; i < 3; i++) begin
            flush[i] = 0; winc[i] = 0; rinc[i] = 0; wdata[i] = 0; rcv[i] = 0; sent[i] = 0;
        end
        repeat (2) @(posedge clk);
        #1 rst_n = 1;

        // asynchronous reset in the middle of a cycle
        winc[0] = 1; wdata[0] = 8'h55; tick;
        wdata[0] = 8'h66; tick;
        winc[0] = 0;
        check("pre_rst_count", count[0], 2);
        #2 rst_n = 0;
        #1;
        for (int i = 0; i < 3; i++) begin
            check($sformatf("rst_count%0d", i), count[i], 0);
            check($sformatf("rst_rempty%0d", i), rempty[i], 1);
            check($sformatf("rst_rvalid%0d", i), rvalid[i], 0);
            check($sformatf("rst_rdata%0d", i), rdata[i], 0);
            check($sformatf("rst_wfull%0d", i), wfull[i], 0);
            check($sformatf("rst_afull%0d", i), walmost_full[i], 0);
            check($sformatf("rst_aempty%0d", i), ralmost_empty[i], 1);
            check($sformatf("rst_ovf%0d", i), overflow[i], 0);
            check($sformatf("rst_unf%0d", i), underflow[i], 0);
        end
        @(posedge clk);
        #1 rst_n = 1;

        // fill and drain, standard mode, depth 4
        winc[0] = 1;
        for (int i = 1; i <= 4; i++) begin
            wdata[0] = 8'(i);
            tick;
        end
        check("fill_wfull", wfull[0], 1);
        check("fill_count", count[0], 4);
        wdata[0] = 8'h05; tick;
        winc[0] = 0;
        check("fill_ovf", overflow[0], 1);
        check("fill_count5", count[0], 4);
        rinc[0] = 1;
        for (int i = 1; i <= 4; i++) begin
            tick;
            check("drain_rdata", rdata[0], i);
            check("drain_rvalid", rvalid[0], 1);
        end
        rinc[0] = 0; tick;
        check("drain_rvalid_off", rvalid[0], 0);
        check("drain_rempty", rempty[0], 1);
        check("drain_hold", rdata[0], 4);
        rinc[0] = 1; tick;
        rinc[0] = 0;
        check("drain_unf", underflow[0], 1);
        check("drain_unf_rvalid", rvalid[0], 0);

        // simultaneous read and write
        flush[0] = 1; tick;
        flush[0] = 0;
        check("flush_ovf", overflow[0], 0);
        check("flush_unf", underflow[0], 0);
        winc[0] = 1;
        for (int i = 0; i < 3; i++) begin
            wdata[0] = 8'h10 + 8'(i);
            tick;
        end
        rinc[0] = 1;
        for (int i = 3; i < 13; i++) begin
            wdata[0] = 8'h10 + 8'(i);
            tick;
            check("simul_count", count[0], 3);
        end
        rinc[0] = 0; wdata[0] = 8'h1d; tick;
        check("simul_full", wfull[0], 1);
        rinc[0] = 1; wdata[0] = 8'hee; tick;
        check("full_rw_count", count[0], 3);
        check("full_rw_ovf", overflow[0], 1);
        winc[0] = 0;
        repeat (3) tick;
        rinc[0] = 0;
        check("simul_drained", count[0], 0);
        winc[0] = 1; rinc[0] = 1; wdata[0] = 8'h77; tick;
        winc[0] = 0; rinc[0] = 0;
        check("empty_rw_count", count[0], 1);
        check("empty_rw_unf", underflow[0], 1);
        rinc[0] = 1; tick;
        rinc[0] = 0;
        check("empty_rw_rdata", rdata[0], 8'h77);

        // FWFT: accepting edge, then word visible after the following edge
        winc[1] = 1; wdata[1] = 8'hA5; tick;
        winc[1] = 0;
        check("fwft_still_empty", rempty[1], 1);
        check("fwft_count", count[1], 1);
        tick;
        check("fwft_rempty", rempty[1], 0);
        check("fwft_rdata", rdata[1], 8'hA5);
        rinc[1] = 1; tick;
        rinc[1] = 0;
        check("fwft_consumed", rempty[1], 1);
        check("fwft_count0", count[1], 0);
        winc[1] = 1;
        for (int i = 0; i < 3; i++) begin
            wdata[1] = 8'hB1 + 8'(i);
            tick;
        end
        winc[1] = 0;
        rinc[1] = 1;
        for (int i = 0; i < 3; i++) begin
            check("fwft_b2b_rempty", rempty[1], 0);
            check("fwft_b2b_rdata", rdata[1], 8'hB1 + 8'(i));
            tick;
        end
        check("fwft_b2b_empty", rempty[1], 1);
        tick;
        rinc[1] = 0;
        check("fwft_unf", underflow[1], 1);
        flush[1] = 1; tick;
        flush[1] = 0;
        check("fwft_flush_unf", underflow[1], 0);

        // thresholds, depth 16, AFULL_TH 12, AEMPTY_TH 4
        winc[2] = 1;
        for (int k = 1; k <= 16; k++) begin
            wdata[2] = 8'(k);
            tick;
            check("th_up_count", count[2], k);
            check("th_up_afull", walmost_full[2], k >= 12);
            check("th_up_aempty", ralmost_empty[2], k <= 4);
        end
        winc[2] = 0;
        check("th_wfull", wfull[2], 1);
        rinc[2] = 1;
        for (int k = 15; k >= 0; k--) begin
            tick;
            check("th_dn_afull", walmost_full[2], k >= 12);
            check("th_dn_aempty", ralmost_empty[2], k <= 4);
        end
        rinc[2] = 0;

        // streaming with random stalls through all three FIFOs
        for (int i = 0; i < 3; i++) base[i] = rcv[i];
        for (int c = 0; c < 600; c++) begin
            for (int i = 0; i < 3; i++) begin
                winc[i] = sent[i] < 48 && $urandom_range(0, 3) != 0;
                wdata[i] = 8'($urandom);
                rinc[i] = $urandom_range(0, 2) != 0;
                acc[i] = winc[i] && !wfull[i];
            end
            tick;
            for (int i = 0; i < 3; i++) if (acc[i]) sent[i]++;
        end
        for (int i = 0; i < 3; i++) begin
            winc[i] = 0; rinc[i] = 1;
        end
        repeat (40) tick;
        for (int i = 0; i < 3; i++) begin
            rinc[i] = 0;
            check($sformatf("stream_sent%0d", i), sent[i], 48);
            check($sformatf("stream_rcv%0d", i), rcv[i] - base[i], 48);
            check($sformatf("stream_count%0d", i), count[i], 0);
        end

        // flush with 7 words held and a write pending
        rinc[2] = 1; tick;
        rinc[2] = 0;
        check("pre_flush_unf", underflow[2], 1);
        winc[2] = 1;
        for (int i = 0; i < 7; i++) begin
            wdata[2] = 8'hC0 + 8'(i);
            tick;
        end
        check("pre_flush_count", count[2], 7);
        wdata[2] = 8'hFE; flush[2] = 1; tick;
        flush[2] = 0; winc[2] = 0;
        check("flush_count", count[2], 0);
        check("flush_rempty", rempty[2], 1);
        check("flush_wfull", wfull[2], 0);
        check("flush_rvalid", rvalid[2], 0);
        check("flush_c_ovf", overflow[2], 0);
        check("flush_c_unf", underflow[2], 0);
        tick;
        check("flush_dropped", count[2], 0);
        check("flush_dropped_empty", rempty[2], 1);

        repeat (2) tick;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
